// File: rtl/lstm_seq_ctrl_pkg.sv
// Shared types for the LSTM sequencer: datapath width, FSM state encoding and the
// issue tag that travels alongside each packet through the node pipeline.
package lstm_seq_ctrl_pkg;

  // Datapath word width of the LSTM node.
  localparam int unsigned LSTM_XLEN = 16;

  // Tag field widths are fixed upper bounds; the top zero-extends its narrower
  // unit index / step counter into them (supports up to 256 units, STEP_W <= 16).
  localparam int unsigned TAG_UNIT_W = 8;
  localparam int unsigned TAG_STEP_W = 16;
  localparam int unsigned TAG_W      = 1 + TAG_UNIT_W + TAG_STEP_W;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } lstm_state_e;

  typedef struct packed {
    logic                  valid;
    logic [TAG_UNIT_W-1:0] unit;
    logic [TAG_STEP_W-1:0] step;
  } lstm_tag_t;

  // Build a tag from its fields.
  function automatic lstm_tag_t make_tag(input logic                  valid,
                                         input logic [TAG_UNIT_W-1:0] unit,
                                         input logic [TAG_STEP_W-1:0] step);
    lstm_tag_t t;
    t.valid = valid;
    t.unit  = unit;
    t.step  = step;
    return t;
  endfunction

endpackage

// File: rtl/lstm_seq_ctrl_tag_pipe.sv
// lstm_tag_pipe: fixed-depth shift register of issue tags. A tag pushed at the end
// of the issue cycle appears on o_tag exactly DEPTH cycles after that issue.
// o_empty is high when no stage holds a valid tag.
module lstm_tag_pipe
  import lstm_seq_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [TAG_W-1:0] i_tag,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_empty
);

  lstm_tag_t r_stage [DEPTH];
  logic      w_any_valid;

  // Shift every cycle; synchronous active-low reset flushes all stages.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  // Occupancy: any valid tag anywhere in the pipe.
  always_comb begin
    w_any_valid = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_any_valid = w_any_valid | r_stage[i].valid;
    end
  end

  assign o_tag   = r_stage[DEPTH-1];
  assign o_empty = ~w_any_valid;

endmodule

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: sequencer for one pipelined LSTM node time-multiplexed over
// NUM_UNITS hidden units and seq_len timesteps. Issues gate packets, supplies
// C(t-1) from a local cell buffer, writes back Ct / forwards ht PIPE_LAT cycles
// after issue, and stalls on read-after-write hazards on the cell buffer.
// Optional build macro: LSTM_CTRL_PERF_EN adds the perf_stall counter output.
module lstm_seq_ctrl
  import lstm_seq_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_UNITS = 4,
  parameter  int unsigned PIPE_LAT  = 6,
  parameter  int unsigned STEP_W    = 8,
  localparam int unsigned UNIT_W    = $clog2(NUM_UNITS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [STEP_W-1:0]    seq_len,
  input  logic                 gate_valid,
  output logic                 gate_ready,
  output logic                 node_issue,
  output logic [LSTM_XLEN-1:0] node_c_prev,
  input  logic [LSTM_XLEN-1:0] node_ct,
  input  logic [LSTM_XLEN-1:0] node_ht,
  output logic                 h_valid,
  output logic [LSTM_XLEN-1:0] h_data,
  output logic [UNIT_W-1:0]    h_unit,
  output logic [STEP_W-1:0]    h_step,
  output logic                 busy,
  output logic                 done
`ifdef LSTM_CTRL_PERF_EN
  ,
  output logic [15:0]          perf_stall
`endif
);

  lstm_state_e          r_state;
  lstm_state_e          w_state_next;
  logic [STEP_W-1:0]    r_seq_len;
  logic [UNIT_W-1:0]    r_unit_ptr;
  logic [STEP_W-1:0]    r_step_cnt;
  logic [LSTM_XLEN-1:0] r_cbuf [NUM_UNITS];
  logic [NUM_UNITS-1:0] r_pending;
  logic [NUM_UNITS-1:0] w_pending_next;

  logic                 r_h_valid;
  logic [LSTM_XLEN-1:0] r_h_data;
  logic [UNIT_W-1:0]    r_h_unit;
  logic [STEP_W-1:0]    r_h_step;

  logic                 w_gate_ready;
  logic                 w_fire;
  logic                 w_last_unit;
  logic                 w_last_step;
  logic                 w_start_run;
  logic                 w_pipe_empty;
  lstm_tag_t            w_tag_in;
  lstm_tag_t            w_wb_tag;
  logic                 w_wb_valid;
  logic [UNIT_W-1:0]    w_wb_unit;
  logic                 w_unused_tag;

  // Issue handshake: only in ISSUE, and only when the current unit has no
  // cell-state write outstanding (no bypass from the writeback path).
  assign w_gate_ready = (r_state == StIssue) & ~r_pending[r_unit_ptr];
  assign w_fire       = w_gate_ready & gate_valid;
  assign w_last_unit  = (r_unit_ptr == UNIT_W'(NUM_UNITS - 1));
  assign w_last_step  = (r_step_cnt == (r_seq_len - STEP_W'(1)));

  assign w_tag_in   = make_tag(w_fire, TAG_UNIT_W'(r_unit_ptr), TAG_STEP_W'(r_step_cnt));
  assign w_wb_valid = w_wb_tag.valid;
  assign w_wb_unit  = w_wb_tag.unit[UNIT_W-1:0];
  // Upper tag bits beyond UNIT_W / STEP_W are always zero.
  assign w_unused_tag = ^{w_wb_tag.unit, w_wb_tag.step};

  lstm_tag_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_tag_pipe (
    .clock   (clock),
    .reset   (reset),
    .i_tag   (w_tag_in),
    .o_tag   (w_wb_tag),
    .o_empty (w_pipe_empty)
  );

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_start_run  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          if (seq_len != '0) begin
            w_start_run  = 1'b1;
            w_state_next = StIssue;
          end else begin
            w_state_next = StDone;
          end
        end
      end
      StIssue: begin
        if (w_fire && w_last_unit && w_last_step) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (w_pipe_empty && (r_pending == '0)) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Sequence length latch and unit/step round-robin counters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_seq_len  <= '0;
      r_unit_ptr <= '0;
      r_step_cnt <= '0;
    end else if (w_start_run) begin
      r_seq_len  <= seq_len;
      r_unit_ptr <= '0;
      r_step_cnt <= '0;
    end else if (w_fire) begin
      if (w_last_unit) begin
        r_unit_ptr <= '0;
        r_step_cnt <= r_step_cnt + STEP_W'(1);
      end else begin
        r_unit_ptr <= r_unit_ptr + UNIT_W'(1);
      end
    end
  end

  // Cell-state buffer: cleared at each new sequence, written on tag exit.
  always_ff @(posedge clock) begin
    if (!reset || w_start_run) begin
      for (int i = 0; i < int'(NUM_UNITS); i++) begin
        r_cbuf[i] <= '0;
      end
    end else if (w_wb_valid) begin
      r_cbuf[w_wb_unit] <= node_ct;
    end
  end

  // Pending bits: set on issue, cleared on writeback. Same-unit overlap cannot
  // happen because a pending unit is never issued.
  always_comb begin
    w_pending_next = r_pending;
    if (w_wb_valid) begin
      w_pending_next[w_wb_unit] = 1'b0;
    end
    if (w_fire) begin
      w_pending_next[r_unit_ptr] = 1'b1;
    end
  end

  // Pending register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  // Registered hidden-output port, one cycle after the tag leaves the pipe.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_h_valid <= 1'b0;
      r_h_data  <= '0;
      r_h_unit  <= '0;
      r_h_step  <= '0;
    end else begin
      r_h_valid <= w_wb_valid;
      if (w_wb_valid) begin
        r_h_data <= node_ht;
        r_h_unit <= w_wb_unit;
        r_h_step <= w_wb_tag.step[STEP_W-1:0];
      end
    end
  end

`ifdef LSTM_CTRL_PERF_EN
  logic [15:0] r_perf_stall;

  // Saturating count of ISSUE cycles where upstream waits on a hazard stall.
  always_ff @(posedge clock) begin
    if (!reset || ((r_state == StIdle) && start)) begin
      r_perf_stall <= '0;
    end else if ((r_state == StIssue) && gate_valid && !w_gate_ready &&
                 (r_perf_stall != 16'hFFFF)) begin
      r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign perf_stall = r_perf_stall;
`endif

  assign gate_ready  = w_gate_ready;
  assign node_issue  = w_fire;
  assign node_c_prev = r_cbuf[r_unit_ptr];
  assign h_valid     = r_h_valid;
  assign h_data      = r_h_data;
  assign h_unit      = r_h_unit;
  assign h_step      = r_h_step;
  assign busy        = (r_state != StIdle);
  assign done        = (r_state == StDone);

endmodule
